// File: rtl/ff_bridge_pipe.sv
// ff_bridge_pipe: per-port register bridge between near-side memory ports
// and a far-side RAM with a fixed read latency. The request bundle is delayed
// by REQ_STAGES and the returned read data by RSP_STAGES. A per-port shift
// register produces the rsp_valid strobe L = REQ_STAGES+RAM_LAT+RSP_STAGES
// cycles after each read. The block also keeps a saturating count of reads
// in flight per port and a registered idle flag.
// Optional feature: define FF_BRIDGE_PIPE_PARITY_EN to generate one even
// parity bit per port over {addr,we,d}, carry it through the request stages,
// and raise the sticky par_err output on a mismatch at the last stage.
module ff_bridge_pipe #(
  parameter int NUM_PORTS  = 8,
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 64,
  parameter int REQ_STAGES = 1,
  parameter int RSP_STAGES = 1,
  parameter int RAM_LAT    = 2
) (
  input  logic                        clk0,
  input  logic                        socket_reset,
  input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
  input  logic [NUM_PORTS-1:0]        req_ce,
  input  logic [NUM_PORTS-1:0]        req_we,
  input  logic [NUM_PORTS*DATA_W-1:0] req_d,
  output logic [NUM_PORTS*ADDR_W-1:0] req_addr_ff,
  output logic [NUM_PORTS-1:0]        req_ce_ff,
  output logic [NUM_PORTS-1:0]        req_we_ff,
  output logic [NUM_PORTS*DATA_W-1:0] req_d_ff,
  input  logic [NUM_PORTS*DATA_W-1:0] rsp_q_ff,
  output logic [NUM_PORTS*DATA_W-1:0] rsp_q,
  output logic [NUM_PORTS-1:0]        rsp_valid,
  output logic [NUM_PORTS*4-1:0]      rd_outstanding,
  output logic                        idle
`ifdef FF_BRIDGE_PIPE_PARITY_EN
  ,
  output logic                        par_err
`endif
);

  localparam int AW_ALL = NUM_PORTS * ADDR_W;
  localparam int DW_ALL = NUM_PORTS * DATA_W;
  localparam int LAT    = REQ_STAGES + RAM_LAT + RSP_STAGES;

  // A read is a chip enable without write enable at the near-side input.
  logic [NUM_PORTS-1:0] rd_hit;

  // Per-port read-tracking shift registers; bit LAT-1 is the strobe.
  logic [LAT-1:0] vld_sr      [NUM_PORTS];
  logic [LAT-1:0] vld_sr_next [NUM_PORTS];

  // Per-port saturating in-flight read counters.
  logic [3:0] rd_cnt      [NUM_PORTS];
  logic [3:0] rd_cnt_next [NUM_PORTS];

  // Any chip enable that will sit in a request stage after the next edge.
  logic ce_busy_next;
  logic idle_next;

`ifdef FF_BRIDGE_PIPE_PARITY_EN
  logic [NUM_PORTS-1:0] par_in;
  logic [NUM_PORTS-1:0] par_ff;
  logic [NUM_PORTS-1:0] par_calc;
  logic                 par_bad;
`endif

  assign rd_hit = req_ce & ~req_we;

  // ---------------------------------------------------------------------
  // Request path
  // ---------------------------------------------------------------------
  generate
    if (REQ_STAGES == 0) begin : g_req_pass
      assign req_addr_ff  = req_addr;
      assign req_ce_ff    = req_ce;
      assign req_we_ff    = req_we;
      assign req_d_ff     = req_d;
      // Nothing is ever held in a request register in passthrough mode.
      assign ce_busy_next = 1'b0;
`ifdef FF_BRIDGE_PIPE_PARITY_EN
      assign par_ff       = par_in;
`endif
    end else begin : g_req_pipe
      logic [AW_ALL-1:0]    addr_q [REQ_STAGES];
      logic [NUM_PORTS-1:0] ce_q   [REQ_STAGES];
      logic [NUM_PORTS-1:0] we_q   [REQ_STAGES];
      logic [DW_ALL-1:0]    d_q    [REQ_STAGES];

      // Shift the whole request bundle one stage per clock, in order.
      always_ff @(posedge clk0 or posedge socket_reset) begin
        if (socket_reset) begin
          for (int s = 0; s < REQ_STAGES; s++) begin
            addr_q[s] <= '0;
            ce_q[s]   <= '0;
            we_q[s]   <= '0;
            d_q[s]    <= '0;
          end
        end else begin
          addr_q[0] <= req_addr;
          ce_q[0]   <= req_ce;
          we_q[0]   <= req_we;
          d_q[0]    <= req_d;
          for (int s = 1; s < REQ_STAGES; s++) begin
            addr_q[s] <= addr_q[s-1];
            ce_q[s]   <= ce_q[s-1];
            we_q[s]   <= we_q[s-1];
            d_q[s]    <= d_q[s-1];
          end
        end
      end

      assign req_addr_ff = addr_q[REQ_STAGES-1];
      assign req_ce_ff   = ce_q[REQ_STAGES-1];
      assign req_we_ff   = we_q[REQ_STAGES-1];
      assign req_d_ff    = d_q[REQ_STAGES-1];

      // Stage s after the edge holds what stage s-1 (or the input) holds now.
      always_comb begin
        ce_busy_next = |req_ce;
        for (int s = 0; s < REQ_STAGES - 1; s++) begin
          ce_busy_next = ce_busy_next | (|ce_q[s]);
        end
      end

`ifdef FF_BRIDGE_PIPE_PARITY_EN
      logic [NUM_PORTS-1:0] par_q [REQ_STAGES];

      // Carry the input parity alongside the request bundle.
      always_ff @(posedge clk0 or posedge socket_reset) begin
        if (socket_reset) begin
          for (int s = 0; s < REQ_STAGES; s++) begin
            par_q[s] <= '0;
          end
        end else begin
          par_q[0] <= par_in;
          for (int s = 1; s < REQ_STAGES; s++) begin
            par_q[s] <= par_q[s-1];
          end
        end
      end

      assign par_ff = par_q[REQ_STAGES-1];
`endif
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Response data path
  // ---------------------------------------------------------------------
  generate
    if (RSP_STAGES == 0) begin : g_rsp_pass
      assign rsp_q = rsp_q_ff;
    end else begin : g_rsp_pipe
      logic [DW_ALL-1:0] q_q [RSP_STAGES];

      // Delay far-side read data by RSP_STAGES clocks.
      always_ff @(posedge clk0 or posedge socket_reset) begin
        if (socket_reset) begin
          for (int s = 0; s < RSP_STAGES; s++) begin
            q_q[s] <= '0;
          end
        end else begin
          q_q[0] <= rsp_q_ff;
          for (int s = 1; s < RSP_STAGES; s++) begin
            q_q[s] <= q_q[s-1];
          end
        end
      end

      assign rsp_q = q_q[RSP_STAGES-1];
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Read tracking: valid shift registers and in-flight counters
  // ---------------------------------------------------------------------

  // Next value of each shift register: new read enters at bit 0.
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      vld_sr_next[p][0] = rd_hit[p];
      for (int i = 1; i < LAT; i++) begin
        vld_sr_next[p][i] = vld_sr[p][i-1];
      end
    end
  end

  // Strobe and counter outputs are taken straight from registers.
  always_comb begin
    rsp_valid      = '0;
    rd_outstanding = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      rsp_valid[p]              = vld_sr[p][LAT-1];
      rd_outstanding[p*4 +: 4]  = rd_cnt[p];
    end
  end

  // Count up on a read, down on a strobe, hold when both coincide; clamp at 15 and 0.
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      rd_cnt_next[p] = rd_cnt[p];
      if (rd_hit[p] && !rsp_valid[p]) begin
        if (rd_cnt[p] != 4'd15) begin
          rd_cnt_next[p] = rd_cnt[p] + 4'd1;
        end
      end else if (!rd_hit[p] && rsp_valid[p]) begin
        if (rd_cnt[p] != 4'd0) begin
          rd_cnt_next[p] = rd_cnt[p] - 4'd1;
        end
      end
    end
  end

  // Register the tracking state; reset discards every read in flight.
  always_ff @(posedge clk0 or posedge socket_reset) begin
    if (socket_reset) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        vld_sr[p] <= '0;
        rd_cnt[p] <= 4'd0;
      end
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        vld_sr[p] <= vld_sr_next[p];
        rd_cnt[p] <= rd_cnt_next[p];
      end
    end
  end

  // ---------------------------------------------------------------------
  // Idle flag
  // ---------------------------------------------------------------------

  // Idle is computed from next-state values so the flop matches the
  // contents of the other registers in the same cycle.
  always_comb begin
    idle_next = ~ce_busy_next;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if ((vld_sr_next[p] != '0) || (rd_cnt_next[p] != 4'd0)) begin
        idle_next = 1'b0;
      end
    end
  end

  // Idle register; comes out of reset set because nothing is in flight.
  always_ff @(posedge clk0 or posedge socket_reset) begin
    if (socket_reset) begin
      idle <= 1'b1;
    end else begin
      idle <= idle_next;
    end
  end

`ifdef FF_BRIDGE_PIPE_PARITY_EN
  // ---------------------------------------------------------------------
  // Parity generation and last-stage check
  // ---------------------------------------------------------------------

  // Even parity over {addr,we,d} at the input and again at the last stage.
  always_comb begin
    par_in   = '0;
    par_calc = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      par_in[p]   = ^{req_addr[p*ADDR_W +: ADDR_W], req_we[p], req_d[p*DATA_W +: DATA_W]};
      par_calc[p] = ^{req_addr_ff[p*ADDR_W +: ADDR_W], req_we_ff[p],
                      req_d_ff[p*DATA_W +: DATA_W]};
    end
  end

  assign par_bad = |(req_ce_ff & (par_calc ^ par_ff));

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk0 or posedge socket_reset) begin
    if (socket_reset) begin
      par_err <= 1'b0;
    end else if (par_bad) begin
      par_err <= 1'b1;
    end
  end
`endif

endmodule
